// File: rtl/mux_scan_nx1_if.sv
// Channel bus for mux_scan_nx1: packed channel data and controls in, registered selection out.
// No handshake: the consumer qualifies y with y_valid. MUX_SCAN_PARITY_EN adds y_parity.
interface mux_scan_nx1_if #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 1,
    parameter int SEL_W = $clog2(N_CH)
);
    logic [N_CH*WIDTH-1:0] in;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic [N_CH-1:0]       en_mask;
    logic [WIDTH-1:0]      y;
    logic                  y_valid;
    logic [SEL_W-1:0]      cur_ch;
    logic                  frame_done;
`ifdef MUX_SCAN_PARITY_EN
    logic                  y_parity;

    modport master (output in, sel, mode, en_mask,
                    input  y, y_valid, cur_ch, frame_done, y_parity);
    modport slave  (input  in, sel, mode, en_mask,
                    output y, y_valid, cur_ch, frame_done, y_parity);
`else
    modport master (output in, sel, mode, en_mask,
                    input  y, y_valid, cur_ch, frame_done);
    modport slave  (input  in, sel, mode, en_mask,
                    output y, y_valid, cur_ch, frame_done);
`endif
endinterface

// File: rtl/mux_scan_nx1.sv
// Registered N_CH x WIDTH mux with manual select or masked round-robin scan (DWELL cycles/channel).
// Latency 1 cycle from sel/in to y. No backpressure: y updates every cycle, qualified by y_valid.
// Optional MUX_SCAN_PARITY_EN adds y_parity = ^y, registered alongside y.
module mux_scan_nx1 #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 1,
    parameter int DWELL = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_nx1_if.slave bus
);
    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] cur_q, ch_nxt;
    logic [WIDTH-1:0] y_q, y_nxt;
    logic             vld_q, vld_nxt;
    logic             fd_q, fd_nxt;

    logic [WIDTH-1:0] chan [N_CH];
    logic [SEL_W-1:0] low_ch, up_ch;
    logic             low_ok, up_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign chan[k] = bus.in[k*WIDTH +: WIDTH];
    end

    // Lowest enabled channel overall (frame start / wrap) and lowest enabled above cur_q.
    always_comb begin
        low_ch = '0;
        low_ok = 1'b0;
        up_ch  = '0;
        up_ok  = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bus.en_mask[k]) begin
                low_ch = SEL_W'(k);
                low_ok = 1'b1;
                if (SEL_W'(k) > cur_q) begin
                    up_ch = SEL_W'(k);
                    up_ok = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = bus.mode ? SCAN : IDLE;
        cnt_nxt   = '0;
        ch_nxt    = cur_q;
        vld_nxt   = 1'b0;
        fd_nxt    = 1'b0;
        if (!bus.mode) begin
            ch_nxt  = bus.sel;
            vld_nxt = (32'(bus.sel) < N_CH);
        end else if (state == IDLE || !vld_q) begin
            // Frame start, either on scan entry or after an empty mask.
            if (low_ok) ch_nxt = low_ch;
            vld_nxt = low_ok;
        end else if (cnt != CNT_LAST) begin
            cnt_nxt = cnt + 1'b1;
            vld_nxt = 1'b1;
        end else if (up_ok) begin
            ch_nxt  = up_ch;
            vld_nxt = 1'b1;
        end else if (low_ok) begin
            ch_nxt  = low_ch;
            vld_nxt = 1'b1;
            fd_nxt  = 1'b1;
        end
        y_nxt = vld_nxt ? chan[ch_nxt] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            cur_q <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            cur_q <= ch_nxt;
            y_q   <= y_nxt;
            vld_q <= vld_nxt;
            fd_q  <= fd_nxt;
        end
    end

    assign bus.y          = y_q;
    assign bus.y_valid    = vld_q;
    assign bus.cur_ch     = cur_q;
    assign bus.frame_done = fd_q;

`ifdef MUX_SCAN_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= ^y_nxt;
    end

    assign bus.y_parity = par_q;
`endif
endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: three configurations share one clock and reset.
module tb_mux_scan_nx1;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_nx1_if #(.N_CH(8), .WIDTH(1)) if1 ();
    mux_scan_nx1_if #(.N_CH(8), .WIDTH(8)) if2 ();
    mux_scan_nx1_if #(.N_CH(5), .WIDTH(8)) if3 ();

    mux_scan_nx1 #(.N_CH(8), .WIDTH(1), .DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mux_scan_nx1 #(.N_CH(8), .WIDTH(8), .DWELL(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    mux_scan_nx1 #(.N_CH(5), .WIDTH(8), .DWELL(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int sel; int y; int vld; int cur; int par; } man_t;
    typedef struct { int cur; int fd; } scn_t;

    man_t m1 [8];
    man_t m3 [6];
    scn_t s2 [13];
    scn_t s3 [5];
    int   d3 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input int cur, input int y, input int vld, input int fd);
        check({tag, ".cur_ch"},     32'(if2.cur_ch),     32'(cur));
        check({tag, ".y"},          32'(if2.y),          32'(y));
        check({tag, ".y_valid"},    32'(if2.y_valid),    32'(vld));
        check({tag, ".frame_done"}, 32'(if2.frame_done), 32'(fd));
    endtask

    initial begin
        rst = 1'b1;
        if1.in = 8'b1010_1010; if1.sel = '0; if1.mode = 1'b0; if1.en_mask = '0;
        if2.sel = '0; if2.mode = 1'b0; if2.en_mask = '0;
        for (int k = 0; k < 8; k++) if2.in[k*8 +: 8] = 8'(k * 16);
        if3.in = {8'h80, 8'h3C, 8'hB5, 8'h22, 8'h11};
        if3.sel = '0; if3.mode = 1'b0; if3.en_mask = '0;

        d3 = '{'h11, 'h22, 'hB5, 'h3C, 'h80};
        for (int i = 0; i < 8; i++) m1[i] = '{i, i % 2, 1, i, 0};
        m3[0] = '{2, 'hB5, 1, 2, 1};
        m3[1] = '{6, 0,    0, 6, 0};
        m3[2] = '{4, 'h80, 1, 4, 1};
        m3[3] = '{3, 'h3C, 1, 3, 0};
        m3[4] = '{5, 0,    0, 5, 0};
        m3[5] = '{1, 'h22, 1, 1, 0};
        s2 = '{'{1,0}, '{1,0}, '{2,0}, '{2,0}, '{4,0}, '{4,0}, '{7,0},
               '{7,0}, '{1,1}, '{1,0}, '{2,0}, '{2,0}, '{4,0}};
        s3 = '{'{0,0}, '{2,0}, '{4,0}, '{0,1}, '{2,0}};

        #12;
        chk2("reset", 0, 0, 0, 0);
        #5 rst = 1'b0;

        // Manual sweep, 1-bit channels.
        for (int i = 0; i < 8; i++) begin
            if1.sel = 3'(m1[i].sel);
            tick;
            check($sformatf("man1[%0d].y", i),      32'(if1.y),       32'(m1[i].y));
            check($sformatf("man1[%0d].cur", i),    32'(if1.cur_ch),  32'(m1[i].cur));
            check($sformatf("man1[%0d].vld", i),    32'(if1.y_valid), 32'(m1[i].vld));
        end

        // Manual select on a 5-channel mux, including out-of-range selects.
        for (int i = 0; i < 6; i++) begin
            if3.sel = 3'(m3[i].sel);
            tick;
            check($sformatf("man3[%0d].y", i),   32'(if3.y),       32'(m3[i].y));
            check($sformatf("man3[%0d].vld", i), 32'(if3.y_valid), 32'(m3[i].vld));
            check($sformatf("man3[%0d].cur", i), 32'(if3.cur_ch),  32'(m3[i].cur));
`ifdef MUX_SCAN_PARITY_EN
            check($sformatf("man3[%0d].par", i), 32'(if3.y_parity), 32'(m3[i].par));
`endif
        end

        // DWELL=1 scan: advances every cycle.
        if3.en_mask = 5'b10101;
        if3.mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("scan3[%0d].cur", i), 32'(if3.cur_ch),     32'(s3[i].cur));
            check($sformatf("scan3[%0d].fd", i),  32'(if3.frame_done), 32'(s3[i].fd));
            check($sformatf("scan3[%0d].y", i),   32'(if3.y),          32'(d3[s3[i].cur]));
        end
        if3.mode = 1'b0;

        // DWELL=2 scan over channels 1,2,4,7.
        if2.en_mask = 8'b1001_0110;
        if2.mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick;
            chk2($sformatf("scan2[%0d]", i), s2[i].cur, s2[i].cur * 16, 1, s2[i].fd);
        end

        // Leave scan at cur_ch=4 with one dwell cycle left.
        if2.mode = 1'b0;
        if2.sel = 3'd6;
        tick;
        chk2("modesw", 6, 'h60, 1, 0);

        // Empty mask, then a single enabled channel.
        if2.en_mask = '0;
        if2.mode = 1'b1;
        tick; chk2("mask0a", 6, 0, 0, 0);
        tick; chk2("mask0b", 6, 0, 0, 0);
        if2.en_mask = 8'b0000_1000;
        tick; chk2("one_a", 3, 'h30, 1, 0);
        tick; chk2("one_b", 3, 'h30, 1, 0);
        tick; chk2("one_c", 3, 'h30, 1, 1);
        tick; chk2("one_d", 3, 'h30, 1, 0);
        tick; chk2("one_e", 3, 'h30, 1, 1);

        // Mask cleared mid-dwell: dwell completes, then output goes invalid.
        if2.en_mask = '0;
        tick; chk2("clr_a", 3, 'h30, 1, 0);
        tick; chk2("clr_b", 3, 0, 0, 0);

        // Resume, then asynchronous reset between edges.
        if2.en_mask = 8'b1001_0110;
        tick; chk2("resume", 1, 'h10, 1, 0);
        tick;
        #3 rst = 1'b1;
        #1 chk2("arst", 0, 0, 0, 0);
        #2 rst = 1'b0;
        tick; chk2("restart", 1, 'h10, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
Parametrised, registered N-channel by WIDTH-bit multiplexer. It generalises the fixed 8:1 combinational mux and supports two modes:
- Manual mode: external select.
- Scan mode: autonomous round-robin across the channels enabled in a mask, with a programmable dwell per channel and an end-of-frame pulse.

It sits between multi-channel sample sources and a single shared downstream consumer (serialiser, logger, display).

Parameters:
N_CH, 8, number of input channels (2..256)
WIDTH, 1, bits per channel
DWELL, 1, cycles each channel is held in scan mode (>=1)
SEL_W, $clog2(N_CH), derived select/channel-index width; not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in  input  N_CH*WIDTH  packed channel data; channel k = in[k*WIDTH +: WIDTH]
sel  input  SEL_W  manual-mode channel select
mode  input  1  0 = manual, 1 = scan
en_mask  input  N_CH  scan-mode channel enables; bit k enables channel k
y  output  WIDTH  registered selected data
y_valid  output  1  y holds valid channel data
cur_ch  output  SEL_W  channel index that y was taken from
frame_done  output  1  one-cycle pulse: last enabled channel's dwell has completed

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately and holds while high):
  - Outputs: y=0, y_valid=0, cur_ch=0, frame_done=0.
  - Internal: state=IDLE, dwell counter=0.
- All outputs are registered. y, y_valid and cur_ch are mutually aligned: y is `in` sampled at the same edge that loads cur_ch.
- FSM states:
  - IDLE: manual operation.
  - SCAN: autonomous stepping.
- IDLE:
  - Each edge: cur_ch<=sel, y<=in[sel], y_valid<=1. Latency is 1 cycle from sel/in to y.
  - sel >= N_CH (non-power-of-2 N_CH): y<=0, y_valid<=0, cur_ch<=sel.
  - frame_done=0.
  - mode=1 -> SCAN.
- Entry to SCAN (first SCAN cycle):
  - cur_ch <= lowest enabled channel; dwell counter <= 0.
  - en_mask==0: y<=0, y_valid<=0; remain in SCAN, re-evaluating the mask every cycle.
- SCAN, steady state:
  - Each edge: y<=in[cur_ch] (live data, not frozen) and y_valid<=1.
  - Dwell counter increments each cycle. When it reaches DWELL-1 it clears, and cur_ch advances to the next enabled channel in circular order (lowest enabled index > cur_ch).
  - If no enabled index > cur_ch, wrap to the lowest enabled index and assert frame_done for exactly that one cycle, coincident with the first y of the new frame.
  - en_mask is sampled only at dwell expiry; a channel disabled mid-dwell completes its dwell.
  - Exactly one channel enabled: cur_ch stays fixed and frame_done pulses once every DWELL cycles.
  - Mask goes to 0 at expiry: y_valid<=0, y<=0, cur_ch held; resume at the lowest enabled channel when the mask becomes nonzero.
- mode 1->0 at any point: next edge -> IDLE with manual behaviour on that same edge (y<=in[sel]). The dwell counter clears and no frame_done is emitted.
- mode 0->1 while in SCAN has no meaning; mode is a level.
- DWELL=1: the channel advances every cycle.

Optional Feature:
MUX_SCAN_PARITY_EN
- Defined: adds output y_parity (1 bit, registered, aligned with y) = XOR-reduce of y. Reset value 0; 0 whenever y_valid=0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Manual sweep: N_CH=8, WIDTH=1, in=8'b10101010, mode=0, sel 0..7 one per cycle -> y one cycle later = 0,1,0,1,0,1,0,1; cur_ch tracks sel; y_valid=1.
- Scan with mask: N_CH=8, WIDTH=8, in[k]=k*16, DWELL=2, en_mask=8'b1001_0110.
  - cur_ch sequence 1,1,2,2,4,4,7,7,1,...; y = 0x10,0x20,0x40,0x70.
  - frame_done high only on the cycle cur_ch returns to 1.
- Degenerate masks: en_mask=0 -> y_valid=0, y=0. Then en_mask=8'b0000_1000 -> cur_ch=3 steady, frame_done every DWELL cycles.
- Mode switch mid-scan: in SCAN at cur_ch=4 with 1 dwell cycle remaining, set mode=0, sel=6 -> next edge cur_ch=6, y=in[6], no frame_done.
- Async reset mid-scan: assert rst between edges -> y=0, y_valid=0, cur_ch=0, frame_done=0 immediately. Release with mode=1 -> scan restarts at the lowest enabled channel.
- Non-power-of-2: N_CH=5, mode=0, sel=6 -> y=0, y_valid=0. With MUX_SCAN_PARITY_EN and WIDTH=8, in[2]=8'hB5, sel=2 -> y=8'hB5, y_parity=1.
